// File: rtl/lock_key_pkg.sv
// Shared definitions for the combination-lock key path: FSM encoding,
// default sizing, the demo key and the parity helper.
package lock_key_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_PULSE = 2'b01,
    ST_GAP   = 2'b10,
    ST_DONE  = 2'b11
  } state_e;

  localparam int DEF_CODE_W = 4;
  localparam int DEF_GAP    = 1;

  localparam logic [3:0] DEMO_KEY = 4'b1011;

  // Even parity over a zero-extended code word.
  function automatic logic even_parity(input logic [15:0] i_v);
    return ^i_v;
  endfunction

endpackage

// File: rtl/lock_key_gap_cnt.sv
// Loadable 4-bit down-counter with enable and zero flag; times the idle
// interval between key pulses.
module lock_key_gap_cnt
  import lock_key_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_load,
  input  logic       i_en,
  input  logic [3:0] i_load_val,
  output logic       o_zero
);

  logic [3:0] r_cnt;

  // Count register: load wins over enable, saturates at zero.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= 4'd0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_en && (r_cnt != 4'd0)) begin
      r_cnt <= r_cnt - 4'd1;
    end else begin
      r_cnt <= r_cnt;
    end
  end

  assign o_zero = (r_cnt == 4'd0);

endmodule

// File: rtl/lock_key_tx.sv
// Serial key transmitter: sends a latched code MSB-first as A (1) / B (0)
// pulses separated by GAP idle cycles. LOCK_KEY_TX_PARITY_EN appends an even-parity pulse.
module lock_key_tx
  import lock_key_pkg::*;
#(
  parameter int CODE_W = DEF_CODE_W,
  parameter int GAP    = DEF_GAP
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic [CODE_W-1:0] i_code,
  output logic              o_a_out,
  output logic              o_b_out,
  output logic              o_busy,
  output logic              o_done
);

`ifdef LOCK_KEY_TX_PARITY_EN
  localparam int PAR_W = 1;
`else
  localparam int PAR_W = 0;
`endif

  localparam int         N_BITS   = CODE_W + PAR_W;
  localparam logic [4:0] N_LOAD   = 5'(N_BITS);
  localparam logic [3:0] GAP_LOAD = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

  state_e              r_state;
  state_e              w_state_nxt;
  logic [N_BITS-1:0]   r_shift;
  logic [N_BITS-1:0]   w_shift_load;
  logic [4:0]          r_bits_left;
  logic                w_gap_load;
  logic                w_gap_en;
  logic                w_gap_zero;
  logic                r_a_out;
  logic                r_b_out;
  logic                r_busy;
  logic                r_done;

`ifdef LOCK_KEY_TX_PARITY_EN
  assign w_shift_load = {i_code, even_parity(16'(i_code))};
`else
  assign w_shift_load = i_code;
`endif

  lock_key_gap_cnt u_gap_cnt (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_load     (w_gap_load),
    .i_en       (w_gap_en),
    .i_load_val (GAP_LOAD),
    .o_zero     (w_gap_zero)
  );

  // Next-state decode; the bit counter is already decremented while in GAP.
  always_comb begin
    w_state_nxt = r_state;
    w_gap_load  = 1'b0;
    w_gap_en    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_start) begin
          w_state_nxt = ST_PULSE;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_PULSE: begin
        if (GAP > 0) begin
          w_state_nxt = ST_GAP;
          w_gap_load  = 1'b1;
        end else if (r_bits_left > 5'd1) begin
          w_state_nxt = ST_PULSE;
        end else begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_GAP: begin
        if (!w_gap_zero) begin
          w_gap_en    = 1'b1;
          w_state_nxt = ST_GAP;
        end else if (r_bits_left != 5'd0) begin
          w_state_nxt = ST_PULSE;
        end else begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State, datapath and output registers; outputs reflect the state one cycle back.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= ST_IDLE;
      r_shift     <= '0;
      r_bits_left <= 5'd0;
      r_a_out     <= 1'b0;
      r_b_out     <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_a_out <= (r_state == ST_PULSE) &&  r_shift[N_BITS-1];
      r_b_out <= (r_state == ST_PULSE) && !r_shift[N_BITS-1];
      r_busy  <= (r_state != ST_IDLE);
      r_done  <= (r_state == ST_DONE);
      if ((r_state == ST_IDLE) && i_start) begin
        r_shift     <= w_shift_load;
        r_bits_left <= N_LOAD;
      end else if (r_state == ST_PULSE) begin
        r_shift     <= r_shift << 1;
        r_bits_left <= r_bits_left - 5'd1;
      end else begin
        r_shift     <= r_shift;
        r_bits_left <= r_bits_left;
      end
    end
  end

  assign o_a_out = r_a_out;
  assign o_b_out = r_b_out;
  assign o_busy  = r_busy;
  assign o_done  = r_done;

endmodule
